fft_bin_reader: RTL and testbench

Read-side consumer of the trigger FFT output RAM. Waits for the FFT to finish writing a frame, then scans the positive-half bins through the RAM read port. Computes each bin's absolute value, tracks the spectral peak, and asserts trigger when any bin in a selectable frequency window reaches the threshold. Sits between the trigger FFT output RAM and the top-level trigger/capture logic.

---
 rtl/fft_trigger_pkg.sv | 32 +++
 rtl/fft_abs_mag.sv | 12 +
 rtl/fft_bin_reader.sv | 254 +++++++++++++++++++++++++
 tb/tb_fft_bin_reader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_trigger_pkg.sv
// Shared constants and encodings for the trigger FFT read-side logic.
package fft_trigger_pkg;

  localparam int FFT_POINTS   = 64;
  localparam int NUM_BINS     = FFT_POINTS / 2;
  localparam int THRESH_SHIFT = 5;

  typedef enum logic [2:0] {
    WAIT_WRITE = 3'd0,
    WAIT_DONE  = 3'd1,
    SCAN       = 3'd2,
    DRAIN      = 3'd3,
    REPORT     = 3'd4
  } reader_state_t;

  // General counter select codes
  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    HOLD  = 2'd1,
    COUNT = 2'd2
  } count_sel_t;

  // Next value of a 6-bit general counter for a given select code
  function automatic logic [5:0] count_next(input count_sel_t sel, input logic [5:0] cur);
    case (sel)
      ZERO:    return 6'd0;
      COUNT:   return cur + 6'd1;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/fft_abs_mag.sv
// Combinational absolute value of a signed 10-bit FFT bin.
module fft_abs_mag (
  input  logic signed [9:0] x,
  output logic        [9:0] mag
);

  // -512 wraps to 10'h200, which reads correctly as 512 unsigned
  always_comb begin
    mag = x[9] ? (~x + 10'd1) : x;
  end

endmodule

// File: rtl/fft_bin_reader.sv
// Read-side consumer of the trigger FFT output RAM.
// Waits for a frame write to finish, scans the positive-half bins, reports the
// spectral peak and whether any bin inside the selected window reached the
// threshold.
// Optional build macro FFT_BIN_READER_HOLDOFF_EN: after a triggering report,
// the next HOLDOFF_FRAMES completed frames are counted but not scanned.
//
// state      | meaning
// WAIT_WRITE | idle, waiting for the FFT to start writing (ready low)
// WAIT_DONE  | frame being written, waiting for ready high; latches config
// SCAN       | stepping the RAM read address over all bins
// DRAIN      | collecting the words still in flight in the RAM pipeline
// REPORT     | one cycle: results published, scan_done high
module fft_bin_reader #(
  parameter int NUM_BINS     = fft_trigger_pkg::NUM_BINS,
  parameter int RAM_LATENCY  = 1,
  parameter int THRESH_SHIFT = fft_trigger_pkg::THRESH_SHIFT
`ifdef FFT_BIN_READER_HOLDOFF_EN
  , parameter int HOLDOFF_FRAMES = 4
`endif
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              fft_output_RAM_ready,
  input  logic signed [9:0] fft_output_RAM_data,
  input  logic        [3:0] Frequency,
  input  logic        [1:0] Offset,
  input  logic        [3:0] Threshold,
  output logic        [5:0] fft_output_RAM_addr,
  output logic              trigger,
  output logic              scan_done,
  output logic        [5:0] peak_bin,
  output logic        [9:0] peak_mag,
  output logic              overrun
);

  import fft_trigger_pkg::*;

  reader_state_t state_q, state_d;
  count_sel_t    addr_sel;
  logic [5:0]    addr_q;
  logic [1:0]    drain_q;
  logic          latch_cfg;
  logic          abort;
  logic          report;
  logic          skip;
  logic          hold_active;

  logic [5:0]    lo_q, hi_q, lo_d, hi_d, centre;
  logic [6:0]    hi_sum;
  logic [9:0]    cmp_q, cmp_d;

  logic [RAM_LATENCY-1:0] v_pipe;
  logic [5:0]             tag_pipe [RAM_LATENCY];
  logic                   v_out;
  logic [5:0]             tag_out;
  logic [9:0]             mag;

  logic       acc_hit_q, acc_hit_d;
  logic [9:0] acc_mag_q, acc_mag_d;
  logic [5:0] acc_bin_q, acc_bin_d;

  fft_abs_mag u_abs (
    .x   (fft_output_RAM_data),
    .mag (mag)
  );

  assign v_out               = v_pipe[RAM_LATENCY-1];
  assign tag_out             = tag_pipe[RAM_LATENCY-1];
  assign fft_output_RAM_addr = addr_q;

`ifdef FFT_BIN_READER_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
  logic [HW-1:0] hold_q;

  assign hold_active = (hold_q != '0);

  // Holdoff frame counter: armed by a triggering report, spent by skipped frames
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      hold_q <= '0;
    end else if (report && acc_hit_d) begin
      hold_q <= HW'(HOLDOFF_FRAMES);
    end else if (skip) begin
      hold_q <= hold_q - 1'b1;
    end
  end
`else
  assign hold_active = 1'b0;
`endif

  // Window bounds and compare value derived from the live config inputs
  always_comb begin
    centre = {1'b0, Frequency, 1'b0};
    hi_sum = {1'b0, centre} + {5'b0, Offset};
    lo_d   = (centre >= {4'b0, Offset}) ? centre - {4'b0, Offset} : 6'd0;
    hi_d   = (hi_sum > 7'(NUM_BINS - 1)) ? 6'(NUM_BINS - 1) : hi_sum[5:0];
    cmp_d  = {6'b0, Threshold} << THRESH_SHIFT;
  end

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= WAIT_WRITE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    addr_sel  = ZERO;
    latch_cfg = 1'b0;
    abort     = 1'b0;
    report    = 1'b0;
    skip      = 1'b0;
    unique case (state_q)
      WAIT_WRITE: begin
        if (!fft_output_RAM_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fft_output_RAM_ready) begin
          if (hold_active) begin
            skip    = 1'b1;
            state_d = WAIT_WRITE;
          end else begin
            latch_cfg = 1'b1;
            state_d   = SCAN;
          end
        end
      end
      SCAN: begin
        if (!fft_output_RAM_ready) begin
          abort   = 1'b1;
          state_d = WAIT_DONE;
        end else if (addr_q == 6'(NUM_BINS - 1)) begin
          state_d = DRAIN;
        end else begin
          addr_sel = COUNT;
        end
      end
      DRAIN: begin
        if (!fft_output_RAM_ready) begin
          abort   = 1'b1;
          state_d = WAIT_DONE;
        end else if (drain_q == 2'd0) begin
          report  = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        // A write starting right away must not be missed
        state_d = fft_output_RAM_ready ? WAIT_WRITE : WAIT_DONE;
      end
      default: state_d = WAIT_WRITE;
    endcase
  end

  // Read address and drain down-counter
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      addr_q  <= 6'd0;
      drain_q <= 2'd0;
    end else begin
      addr_q <= count_next(addr_sel, addr_q);
      if (state_q == SCAN) begin
        drain_q <= 2'(RAM_LATENCY - 1);
      end else if (state_q == DRAIN && drain_q != 2'd0) begin
        drain_q <= drain_q - 2'd1;
      end
    end
  end

  // Config snapshot taken when the frame write completes
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      lo_q  <= 6'd0;
      hi_q  <= 6'd0;
      cmp_q <= 10'd0;
    end else if (latch_cfg) begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      cmp_q <= cmp_d;
    end
  end

  // Delay line tagging each returned RAM word with its bin index
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      v_pipe <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) tag_pipe[i] <= 6'd0;
    end else begin
      v_pipe[0]   <= (state_q == SCAN) && !abort;
      tag_pipe[0] <= addr_q;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        v_pipe[i]   <= v_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Accumulator update including the word arriving this cycle; strict compare
  // keeps the lowest bin on ties because bins arrive in ascending order
  always_comb begin
    acc_hit_d = acc_hit_q;
    acc_mag_d = acc_mag_q;
    acc_bin_d = acc_bin_q;
    if (v_out) begin
      if (mag > acc_mag_q) begin
        acc_mag_d = mag;
        acc_bin_d = tag_out;
      end
      if (tag_out >= lo_q && tag_out <= hi_q && mag >= cmp_q) acc_hit_d = 1'b1;
    end
  end

  // Scan accumulators, cleared at the start of every scan
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      acc_hit_q <= 1'b0;
      acc_mag_q <= 10'd0;
      acc_bin_q <= 6'd0;
    end else if (latch_cfg) begin
      acc_hit_q <= 1'b0;
      acc_mag_q <= 10'd0;
      acc_bin_q <= 6'd0;
    end else begin
      acc_hit_q <= acc_hit_d;
      acc_mag_q <= acc_mag_d;
      acc_bin_q <= acc_bin_d;
    end
  end

  // Published results and status pulses
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      trigger   <= 1'b0;
      scan_done <= 1'b0;
      overrun   <= 1'b0;
      peak_bin  <= 6'd0;
      peak_mag  <= 10'd0;
    end else begin
      scan_done <= report;
      overrun   <= abort;
      if (report) begin
        trigger  <= acc_hit_d;
        peak_bin <= acc_bin_d;
        peak_mag <= acc_mag_d;
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_reader.sv
// Self-checking bench for fft_bin_reader with a registered-read RAM model.
`timescale 1ns/1ps
module tb_fft_bin_reader;

  localparam int NB     = 32;
  localparam int LAT    = 1;
  localparam int HOLD_N = 4;
  localparam int REPORT_CYC = NB + LAT + 1;

  logic              clk = 1'b0;
  logic              reset_b;
  logic              ready;
  logic signed [9:0] data;
  logic        [3:0] freq;
  logic        [1:0] off;
  logic        [3:0] thr;
  logic        [5:0] addr;
  logic              trigger;
  logic              scan_done;
  logic        [5:0] peak_bin;
  logic        [9:0] peak_mag;
  logic              overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int frame [NB];
  int m_trigger, m_bin, m_mag, m_hold;

  always #5 clk = ~clk;

  // RAM with one cycle read latency
  always @(posedge clk) data <= 10'(frame[addr]);

  fft_bin_reader #(.NUM_BINS(NB), .RAM_LATENCY(LAT)) dut (
    .clk                  (clk),
    .reset_b              (reset_b),
    .fft_output_RAM_ready (ready),
    .fft_output_RAM_data  (data),
    .Frequency            (freq),
    .Offset               (off),
    .Threshold            (thr),
    .fft_output_RAM_addr  (addr),
    .trigger              (trigger),
    .scan_done            (scan_done),
    .peak_bin             (peak_bin),
    .peak_mag             (peak_mag),
    .overrun              (overrun)
  );

  task automatic clear_frame();
    for (int i = 0; i < NB; i++) frame[i] = 0;
  endtask

  task automatic apply_reset();
    reset_b = 1'b1;
    ready   = 1'b1;
    #1 reset_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    m_trigger = 0; m_bin = 0; m_mag = 0; m_hold = 0;
  endtask

  // Reference: window, threshold and peak straight from the frame contents
  task automatic model_scan(input int f, input int o, input int t,
                            output int hit, output int pb, output int pm);
    int lo, hi, cmp, m;
    lo = 2 * f - o; if (lo < 0) lo = 0;
    hi = 2 * f + o; if (hi > NB - 1) hi = NB - 1;
    cmp = t * 32;
    hit = 0; pb = 0; pm = 0;
    for (int i = 0; i < NB; i++) begin
      m = (frame[i] < 0) ? -frame[i] : frame[i];
      if (m > pm) begin pm = m; pb = i; end
      if (i >= lo && i <= hi && m >= cmp) hit = 1;
    end
  endtask

  task automatic run_frame(input string name, input int f, input int o, input int t,
                           input bit perturb);
    int hit, pb, pm, n_done, pulses, ovr, addr_err, exp_addr, exp_done;
    bit expect_scan;
    model_scan(f, o, t, hit, pb, pm);
    freq = 4'(f); off = 2'(o); thr = 4'(t);
    expect_scan = (m_hold == 0);
    ready = 1'b0;
    repeat (3) @(negedge clk);
    ready = 1'b1;
    n_done = 0; pulses = 0; ovr = 0; addr_err = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (perturb && n == 5) begin
        freq = 4'($urandom); off = 2'($urandom); thr = 4'($urandom);
      end
      if (scan_done) begin pulses++; if (n_done == 0) n_done = n; end
      if (overrun) ovr++;
      exp_addr = (expect_scan && n <= NB) ? n - 1 : 0;
      if (addr !== 6'(exp_addr)) addr_err++;
    end
    if (expect_scan) begin
      m_trigger = hit; m_bin = pb; m_mag = pm;
`ifdef FFT_BIN_READER_HOLDOFF_EN
      if (hit != 0) m_hold = HOLD_N;
`endif
    end else begin
      m_hold--;
    end
    exp_done = expect_scan ? REPORT_CYC : 0;
    n_checks++;
    if (n_done != exp_done) begin
      n_fail++; $display("FAIL %s scan_done_cycle: got %0d expected %0d", name, n_done, exp_done);
    end
    n_checks++;
    if (pulses != int'(expect_scan)) begin
      n_fail++; $display("FAIL %s scan_done_pulses: got %0d expected %0d", name, pulses, int'(expect_scan));
    end
    n_checks++;
    if (ovr != 0) begin
      n_fail++; $display("FAIL %s overrun_pulses: got %0d expected 0", name, ovr);
    end
    n_checks++;
    if (addr_err != 0) begin
      n_fail++; $display("FAIL %s addr_sequence: got %0d bad cycles expected 0", name, addr_err);
    end
    n_checks++;
    if (trigger !== 1'(m_trigger)) begin
      n_fail++; $display("FAIL %s trigger: got %0b expected %0d", name, trigger, m_trigger);
    end
    n_checks++;
    if (peak_bin !== 6'(m_bin)) begin
      n_fail++; $display("FAIL %s peak_bin: got %0d expected %0d", name, peak_bin, m_bin);
    end
    n_checks++;
    if (peak_mag !== 10'(m_mag)) begin
      n_fail++; $display("FAIL %s peak_mag: got %0d expected %0d", name, peak_mag, m_mag);
    end
  endtask

  task automatic check_outputs(input string name, input logic t, input int pb, input int pm);
    n_checks++;
    if (trigger !== t) begin
      n_fail++; $display("FAIL %s trigger: got %0b expected %0b", name, trigger, t);
    end
    n_checks++;
    if (peak_bin !== 6'(pb)) begin
      n_fail++; $display("FAIL %s peak_bin: got %0d expected %0d", name, peak_bin, pb);
    end
    n_checks++;
    if (peak_mag !== 10'(pm)) begin
      n_fail++; $display("FAIL %s peak_mag: got %0d expected %0d", name, peak_mag, pm);
    end
  endtask

  task automatic test_reset();
    clear_frame();
    freq = 4'd0; off = 2'd0; thr = 4'd0;
    apply_reset();
    check_outputs("reset", 1'b0, 0, 0);
    n_checks++;
    if ({scan_done, overrun, addr} !== 8'd0) begin
      n_fail++; $display("FAIL reset status: got %b expected 0", {scan_done, overrun, addr});
    end
  endtask

  task automatic test_directed();
    apply_reset(); clear_frame(); frame[6] = 300;
    run_frame("bin6_hit", 3, 0, 9, 0);
    check_outputs("bin6_hit_const", 1'b1, 6, 300);
    apply_reset();
    run_frame("bin6_miss", 3, 0, 10, 0);
    check_outputs("bin6_miss_const", 1'b0, 6, 300);
    apply_reset(); clear_frame(); frame[1] = -512;
    run_frame("neg512", 0, 2, 15, 0);
    check_outputs("neg512_const", 1'b1, 1, 512);
    apply_reset(); clear_frame(); frame[4] = 200; frame[9] = 200;
    run_frame("tie", 2, 0, 15, 0);
    check_outputs("tie_const", 1'b0, 4, 200);
    apply_reset(); clear_frame();
    run_frame("zero_thr0", 15, 3, 0, 0);
    check_outputs("zero_thr0_const", 1'b1, 0, 0);
    apply_reset(); clear_frame(); frame[31] = 100;
    run_frame("hi_clamp", 15, 3, 3, 0);
    check_outputs("hi_clamp_const", 1'b1, 31, 100);
    apply_reset(); clear_frame(); frame[12] = -500;
    run_frame("outside_win", 5, 1, 1, 0);
    check_outputs("outside_win_const", 1'b0, 12, 500);
  endtask

  task automatic test_random();
    int a, b;
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 3))
          0:       frame[i] = int'($urandom_range(0, 1023)) - 512;
          1:       frame[i] = 0;
          default: frame[i] = int'($urandom_range(0, 80)) - 40;
        endcase
      end
      if ($urandom_range(0, 2) == 0) begin
        a = int'($urandom_range(0, NB - 1)); b = int'($urandom_range(0, NB - 1));
        frame[a] = frame[b];
      end
      if ($urandom_range(0, 7) == 0) frame[$urandom_range(0, NB - 1)] = -512;
      run_frame("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)), bit'(k % 2));
    end
  endtask

  task automatic test_overrun();
    int n_sd, ovr_a, ovr_b;
    apply_reset(); clear_frame(); frame[20] = 250;
`ifdef FFT_BIN_READER_HOLDOFF_EN
    run_frame("pre_abort", 10, 1, 15, 0);
`else
    run_frame("pre_abort", 10, 1, 7, 0);
`endif
    frame[3] = 500;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    ready = 1'b1;
    n_sd = 0; ovr_a = 0; ovr_b = 0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (scan_done) n_sd++;
      if (n == 11) begin
        n_checks++;
        if (addr !== 6'd10) begin
          n_fail++; $display("FAIL abort_addr: got %0d expected 10", addr);
        end
        ready = 1'b0;
      end
      if (n == 12) ovr_a = int'(overrun);
      if (n == 13) ovr_b = int'(overrun);
    end
    n_checks++;
    if (ovr_a != 1 || ovr_b != 0) begin
      n_fail++; $display("FAIL overrun_pulse: got %0d,%0d expected 1,0", ovr_a, ovr_b);
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (scan_done) n_sd++;
    end
    n_checks++;
    if (n_sd != 0) begin
      n_fail++; $display("FAIL abort_scan_done: got %0d expected 0", n_sd);
    end
    check_outputs("abort_hold", 1'(m_trigger), m_bin, m_mag);
    run_frame("after_abort", 1, 2, 15, 0);
  endtask

  task automatic test_async_reset();
    int n_sd;
    apply_reset(); clear_frame(); frame[6] = 300;
    run_frame("pre_rst", 3, 0, 15, 0);
    ready = 1'b0;
    repeat (3) @(negedge clk);
    ready = 1'b1;
    repeat (15) @(negedge clk);
    #2 reset_b = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 0, 0);
    n_checks++;
    if ({scan_done, overrun, addr} !== 8'd0) begin
      n_fail++; $display("FAIL async_rst status: got %b expected 0", {scan_done, overrun, addr});
    end
    m_trigger = 0; m_bin = 0; m_mag = 0; m_hold = 0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    n_sd = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (scan_done) n_sd++;
    end
    n_checks++;
    if (n_sd != 0) begin
      n_fail++; $display("FAIL post_rst_no_frame scan_done: got %0d expected 0", n_sd);
    end
    run_frame("post_rst", 3, 0, 9, 0);
  endtask

`ifdef FFT_BIN_READER_HOLDOFF_EN
  task automatic test_holdoff();
    apply_reset(); clear_frame(); frame[6] = 300;
    run_frame("ho_trig", 3, 0, 9, 0);
    check_outputs("ho_trig_const", 1'b1, 6, 300);
    for (int k = 0; k < HOLD_N; k++) begin
      run_frame("ho_skip", 3, 0, 9, 0);
      check_outputs("ho_skip_const", 1'b1, 6, 300);
    end
    clear_frame();
    run_frame("ho_resume", 3, 0, 1, 0);
    check_outputs("ho_resume_const", 1'b0, 0, 0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overrun();
    test_async_reset();
`ifdef FFT_BIN_READER_HOLDOFF_EN
    test_holdoff();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
